seq_det_scheduler: RTL
======================

// Module: seq_det_scheduler
// PURPOSE
//  Time-shares one 1011 non-overlapping Moore seq_detector between N_CH requesters.
//  Each requester submits a FRAME_W-bit frame. The block grants requesters round-robin,
//  clears the detector, streams the frame MSB-first into seq_in, counts the hits,
//  then returns {channel, hit count} on a valid/ready result port.
//  It sits between the channel front-ends and the single detector instance.
// PARAMETERS
//  N_CH     4   number of requesters (>=2)
//  FRAME_W  16  bits per frame
//  CNT_W    5   hit-counter width; saturates at 2^CNT_W-1
// PORTS
//  clk         in   1             single clock; all logic acts on its rising edge
//  reset       in   1             synchronous, active-high
//  req_valid   in   N_CH          requester i has a frame pending; held until granted
//  req_frame   in   N_CH*FRAME_W  frame i sits at [i*FRAME_W +: FRAME_W]; MSB is sent first
//  req_ready   out  N_CH          one-hot accept pulse, one cycle, frame captured
//  det_reset   out  1             drives seq_detector.reset
//  det_seq_in  out  1             drives seq_detector.seq_in
//  det_detect  in   1             seq_detector.detect_out (registered Moore output, 1-cycle pulse per match)
//  res_valid   out  1             result available
//  res_ch      out  $clog2(N_CH)  channel of the result
//  res_hits    out  CNT_W         matches found in the frame
//  res_ready   in   1             consumer accepts the result
//  busy        out  1             high whenever the FSM is not in IDLE
// BEHAVIOUR
//  - Reset values: state=IDLE, rr_ptr=0, req_ready=0, det_reset=1, det_seq_in=0,
//    res_valid=0, res_ch=0, res_hits=0, busy=0.
//  - IDLE: if any req_valid, grant the first set bit at or after rr_ptr (wrapping).
//    * req_ready[g]=1 in that same cycle (combinational from state/rr_ptr/req_valid).
//    * Capture req_frame[g] into the shift register, clear the hit counter, set rr_ptr=g+1 (mod N_CH).
//    * Go to CLEAR.
//    No request: stay in IDLE, det_reset=1.
//  - CLEAR, 1 cycle: det_reset=1, det_seq_in=0. Go to SHIFT with bit index k=0.
//  - SHIFT, FRAME_W cycles: det_reset=0, det_seq_in=frame[FRAME_W-1-k]. k increments each cycle.
//    After k=FRAME_W-1, go to DRAIN.
//  - DRAIN, 1 cycle: det_reset=0, det_seq_in=0. Catches the detect pulse for the final bit.
//    Go to REPORT.
//  - Hit counting: in SHIFT and DRAIN, if det_detect=1 then hits+=1, saturating at max.
//    det_detect is ignored in IDLE, CLEAR and REPORT.
//  - REPORT: res_valid=1, res_ch and res_hits stable.
//    * On res_valid&res_ready, go to IDLE; res_valid drops the next cycle.
//    * No new grant occurs in the handshake cycle.
//    * res_ready low holds REPORT indefinitely (backpressure); no other requester is granted meanwhile.
//  - Latency: grant cycle to first res_valid = FRAME_W+3 cycles.
//  - Requesters that drop req_valid before they are granted are simply skipped.
//    req_frame changing after the grant has no effect.
//  - Simultaneous requests: the round-robin pointer resolves them. A channel that was just
//    served has lowest priority on the next grant.
//  - reset in any state, including mid-SHIFT or REPORT: next cycle returns to the reset values.
//    The in-flight frame is discarded and no result is produced.
//  - Only one detector user at a time; det_reset is high whenever the detector is not in use.
// STRUCTURE
//  - Package seq_det_pkg: state enum {IDLE, CLEAR, SHIFT, DRAIN, REPORT} (3-bit encoding),
//    PATTERN=4'b1011 constant for benches, and a function to saturate-increment the hit count.
//  - One sub-module seq_det_rr_arbiter:
//    * inputs: req vector, ptr, enable
//    * outputs: one-hot grant and index
//    * purely combinational
//  - Top level holds the FSM, shift register, bit index, hit counter, rr_ptr and result registers.
//  - The seq_detector instance lives at the parent level.
// TESTING (bench instantiates the scheduler with a real seq_detector; N_CH=4, FRAME_W=16, CNT_W=5)
//  1. ch1 frame 16'hB000, res_ready=1.
//     -> det_seq_in streams 1,0,1,1,0... MSB-first. res_valid appears 19 cycles after grant.
//     res_ch=1, res_hits=1.
//  2. ch0 frame 16'hBBBB.
//     -> res_hits=4. Frame 16'h16C0 (contains 1011011) -> res_hits=1, which proves non-overlap.
//  3. ch0 and ch2 valid together after reset.
//     -> ch0 is served first, then ch2. Re-raise ch0 and ch3 together -> ch3 before ch0.
//  4. Hold res_ready=0 for 10 cycles in REPORT while ch1 is valid.
//     -> res_valid, res_ch and res_hits are held stable, req_ready=0.
//     ch1 is granted only after the handshake.
//  5. Pulse reset at SHIFT k=7.
//     -> next cycle: IDLE, det_reset=1, res_valid=0, rr_ptr=0.
//     A re-issued request completes normally.
//  6. Frame 16'h0000 -> res_hits=0.
//     Frame with a final 1011 at bits [3:0] (16'h000B) -> hits=1, so the DRAIN capture works.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the 1011 sequence-detector scheduler.
//   state_e  : scheduler FSM states (3-bit encoding)
//   PATTERN  : the sequence the detector matches, exported for benches
//   sat_inc  : saturating increment for a counter of a given width
package seq_det_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StClear  = 3'd1,
      StShift  = 3'd2,
      StDrain  = 3'd3,
      StReport = 3'd4
   } state_e;

   localparam logic [3:0] PATTERN = 4'b1011;

   // Counter value is carried zero-extended in 32 bits; width must be < 32.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
      logic [31:0] max_val;
      max_val = (32'd1 << width) - 32'd1;
      return (val >= max_val) ? max_val : val + 32'd1;
   endfunction

endpackage

// File: rtl/seq_det_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr_i, wrapping.
//   req_i   : request vector
//   ptr_i   : highest-priority index this round
//   en_i    : grant enable; no grant is issued while low
//   gnt_o   : one-hot grant
//   idx_o   : index of the granted requester
//   valid_o : a grant was issued
module seq_det_rr_arbiter #(
   parameter int unsigned N_CH = 4
) (
   input  logic [N_CH-1:0]         req_i,
   input  logic [$clog2(N_CH)-1:0] ptr_i,
   input  logic                    en_i,
   output logic [N_CH-1:0]         gnt_o,
   output logic [$clog2(N_CH)-1:0] idx_o,
   output logic                    valid_o
);

   localparam int unsigned IW = $clog2(N_CH);
   localparam int unsigned CW = IW + 1;

   logic [CW-1:0] cand;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         // ptr + offset modulo N_CH; one extra bit holds the sum before wrapping
         cand = CW'(ptr_i) + CW'(i);
         if (cand >= CW'(N_CH)) begin
            cand = cand - CW'(N_CH);
         end
         if (en_i && !valid_o && req_i[cand[IW-1:0]]) begin
            valid_o               = 1'b1;
            idx_o                 = cand[IW-1:0];
            gnt_o[cand[IW-1:0]]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_detector.sv
// Non-overlapping 1011 Moore detector. detect_out is a state decode, so it pulses for one
// cycle after the edge that sampled the final 1 of a match.
//   clk        : clock
//   reset      : synchronous, active-high
//   seq_in     : serial input bit
//   detect_out : match pulse
module seq_detector (
   input  logic clk,
   input  logic reset,
   input  logic seq_in,
   output logic detect_out
);

   typedef enum logic [2:0] {DtIdle, DtGot1, DtGot10, DtGot101, DtFound} det_state_e;

   det_state_e state_q, state_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= DtIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         DtIdle:   state_d = seq_in ? DtGot1   : DtIdle;
         DtGot1:   state_d = seq_in ? DtGot1   : DtGot10;
         DtGot10:  state_d = seq_in ? DtGot101 : DtIdle;
         DtGot101: state_d = seq_in ? DtFound  : DtGot10;
         // Non-overlapping: a match consumes its bits, restart from scratch
         DtFound:  state_d = seq_in ? DtGot1   : DtIdle;
         default:  state_d = DtIdle;
      endcase
   end

   assign detect_out = (state_q == DtFound);

endmodule

// File: rtl/seq_det_scheduler.sv
// Time-shares one 1011 detector between N_CH requesters. Requesters are granted round-robin;
// the granted frame is streamed MSB-first into the detector and the hits are returned with
// the channel number on a valid/ready result port.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_frame : per-channel frame requests; req_ready is the one-hot accept pulse
//   det_reset/det_seq_in: drive the external detector; det_detect is its match pulse
//   res_valid/res_ch/res_hits/res_ready : result handshake
//   busy                : FSM is not idle
module seq_det_scheduler
   import seq_det_pkg::*;
#(
   parameter int unsigned N_CH    = 4,
   parameter int unsigned FRAME_W = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_CH-1:0]           req_valid,
   input  logic [N_CH*FRAME_W-1:0]   req_frame,
   output logic [N_CH-1:0]           req_ready,
   output logic                      det_reset,
   output logic                      det_seq_in,
   input  logic                      det_detect,
   output logic                      res_valid,
   output logic [$clog2(N_CH)-1:0]   res_ch,
   output logic [CNT_W-1:0]          res_hits,
   input  logic                      res_ready,
   output logic                      busy
);

   localparam int unsigned IW = $clog2(N_CH);
   localparam int unsigned KW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

   state_e             state_q, state_d;
   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [KW-1:0]      k_q, k_d;
   logic [CNT_W-1:0]   hits_q, hits_d;
   logic [IW-1:0]      ch_q, ch_d;

   logic [N_CH-1:0]    arb_gnt;
   logic [IW-1:0]      arb_idx;
   logic               arb_valid;

   seq_det_rr_arbiter #(
      .N_CH (N_CH)
   ) u_arb (
      .req_i   (req_valid),
      .ptr_i   (rr_ptr_q),
      .en_i    (state_q == StIdle),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q <= '0;
         frame_q  <= '0;
         k_q      <= '0;
         hits_q   <= '0;
         ch_q     <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         frame_q  <= frame_d;
         k_q      <= k_d;
         hits_q   <= hits_d;
         ch_q     <= ch_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      frame_d  = frame_q;
      k_d      = k_q;
      hits_d   = hits_q;
      ch_d     = ch_q;
      case (state_q)
         StIdle: begin
            if (arb_valid) begin
               frame_d  = req_frame[int'(arb_idx) * FRAME_W +: FRAME_W];
               hits_d   = '0;
               ch_d     = arb_idx;
               // Just-served channel drops to lowest priority
               rr_ptr_d = (arb_idx == IW'(N_CH - 1)) ? '0 : arb_idx + 1'b1;
               state_d  = StClear;
            end
         end
         StClear: begin
            k_d     = '0;
            state_d = StShift;
         end
         StShift: begin
            frame_d = frame_q << 1;
            k_d     = k_q + 1'b1;
            if (det_detect) begin
               hits_d = CNT_W'(sat_inc(32'(hits_q), CNT_W));
            end
            if (k_q == KW'(FRAME_W - 1)) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            // Detect pulse for the last frame bit arrives in this cycle
            if (det_detect) begin
               hits_d = CNT_W'(sat_inc(32'(hits_q), CNT_W));
            end
            state_d = StReport;
         end
         StReport: begin
            if (res_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready  = arb_gnt;  // arbiter is enabled only in IDLE
      det_reset  = 1'b1;
      det_seq_in = 1'b0;
      res_valid  = 1'b0;
      busy       = (state_q != StIdle);
      res_ch     = ch_q;
      res_hits   = hits_q;
      case (state_q)
         StShift: begin
            det_reset  = 1'b0;
            det_seq_in = frame_q[FRAME_W-1];
         end
         StDrain:  det_reset = 1'b0;
         StReport: res_valid = 1'b1;
         default: ;
      endcase
   end

endmodule
